// File: rtl/asi_pkg.sv
// Shared types for the ASI RAM arbiter: arbitration state encoding,
// streak counter width and a small helper to name the opposite side.
package asi_pkg;

    localparam int ASI_CNT_W = 4;
    localparam int ASI_Q_W   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } asi_state_e;

    function automatic asi_state_e asi_other(input asi_state_e s);
        return (s == READ) ? WRITE : READ;
    endfunction

endpackage

// File: rtl/asi_arb_if.sv
// Requester/RAM bundle for the ASI arbiter. The requester side (read and
// write engines) is the master; the arbiter itself is the slave.
interface asi_arb_if #(
    parameter int AXI_DW     = 128,
    parameter int AXI_AW     = 40,
    parameter int AXI_WSTRBW = AXI_DW / 8
);
    logic                  rreq;
    logic                  wreq;
    logic                  rbeat;
    logic                  rlast;
    logic                  wbeat;
    logic                  wlast;
    logic [AXI_AW-1:0]     raddr;
    logic [AXI_AW-1:0]     waddr;
    logic [AXI_DW-1:0]     wdata;
    logic [AXI_WSTRBW-1:0] wstrb;

    logic                  rgnt;
    logic                  wgnt;
    logic [AXI_AW-1:0]     usr_a;
    logic                  usr_ce;
    logic [AXI_DW-1:0]     usr_d;
    logic [AXI_WSTRBW-1:0] usr_we;

    logic                  q_valid;
    logic                  q_last;
    logic                  err_beat;

    modport master (
        output rreq, wreq, rbeat, rlast, wbeat, wlast, raddr, waddr, wdata, wstrb,
        input  rgnt, wgnt, usr_a, usr_ce, usr_d, usr_we, q_valid, q_last, err_beat
    );

    modport slave (
        input  rreq, wreq, rbeat, rlast, wbeat, wlast, raddr, waddr, wdata, wstrb,
        output rgnt, wgnt, usr_a, usr_ce, usr_d, usr_we, q_valid, q_last, err_beat
    );
endinterface

// File: rtl/asi_arb_qpipe.sv
// Fixed-depth delay line that lines up read-beat markers with the RAM's
// read data. Every stage clears on reset so nothing stale emerges later.
module asi_arb_qpipe #(
    parameter int W     = 2,
    parameter int DEPTH = 1
) (
    input  logic         usr_clk,
    input  logic         usr_reset_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_pipe [DEPTH];

    // Shift the markers one stage per clock
    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_q = r_pipe[DEPTH-1];
endmodule

// File: rtl/asi_arb.sv
// Burst-atomic arbiter sharing one single-port RAM between a read engine
// and a write engine. Grants change only at a burst's last beat; a streak
// counter bounds how long one side may starve the other.
module asi_arb
    import asi_pkg::*;
#(
    parameter int AXI_DW     = 128,
    parameter int AXI_AW     = 40,
    parameter int AXI_WSTRBW = AXI_DW / 8,
    parameter int ARB_PRI    = 0,
    parameter int ARB_MAXC   = 4,
    parameter int SLV_WS     = 1
) (
    input  logic      usr_clk,
    input  logic      usr_reset_n,
    asi_arb_if.slave  bus
);
    localparam asi_state_e           PRI_SIDE  = (ARB_PRI != 0) ? READ : WRITE;
    localparam logic [ASI_CNT_W-1:0] MAXC_LAST = ASI_CNT_W'(ARB_MAXC - 1);

    asi_state_e           r_state;
    logic [ASI_CNT_W-1:0] r_cnt;
    logic                 r_rgnt;
    logic                 r_wgnt;
    logic                 r_err;

    asi_state_e            w_other;
    asi_state_e            w_idle_pick;
    logic                  w_cur_req;
    logic                  w_oth_req;
    logic                  w_pri_oth;
    logic                  w_burst_end;
    logic                  w_yield;
    logic                  w_stray;
    logic                  w_rd_fire;
    logic [ASI_Q_W-1:0]    w_q;
    logic [AXI_AW-1:0]     w_addr;
    logic [AXI_DW-1:0]     w_data;
    logic [AXI_WSTRBW-1:0] w_we;

    // Arbitration decision terms relative to the side currently holding the grant
    assign w_other     = asi_other(r_state);
    assign w_idle_pick = (bus.rreq && bus.wreq) ? PRI_SIDE : (bus.rreq ? READ : WRITE);
    assign w_cur_req   = (r_state == READ) ? bus.rreq : bus.wreq;
    assign w_oth_req   = (r_state == READ) ? bus.wreq : bus.rreq;
    assign w_pri_oth   = (w_other == PRI_SIDE);
    assign w_burst_end = ((r_state == READ)  && bus.rbeat && bus.rlast) ||
                         ((r_state == WRITE) && bus.wbeat && bus.wlast);
    assign w_yield     = w_oth_req && (!w_cur_req || w_pri_oth || (r_cnt == MAXC_LAST));

    // Grant FSM: state, streak counter and registered grant outputs move together
    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rgnt  <= 1'b0;
            r_wgnt  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (bus.rreq || bus.wreq) begin
                        r_state <= w_idle_pick;
                        r_rgnt  <= (w_idle_pick == READ);
                        r_wgnt  <= (w_idle_pick == WRITE);
                    end
                end
                READ, WRITE: begin
                    if (w_burst_end) begin
                        if (w_yield) begin
                            r_state <= w_other;
                            r_rgnt  <= (w_other == READ);
                            r_wgnt  <= (w_other == WRITE);
                            r_cnt   <= '0;
                        end else if (w_cur_req) begin
                            // Only a streak that actually keeps someone waiting is counted
                            r_cnt <= w_oth_req ? r_cnt + 1'b1 : '0;
                        end else begin
                            r_state <= IDLE;
                            r_rgnt  <= 1'b0;
                            r_wgnt  <= 1'b0;
                            r_cnt   <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_rgnt  <= 1'b0;
                    r_wgnt  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign w_stray = (bus.rbeat && !r_rgnt) || (bus.wbeat && !r_wgnt);

    // Sticky protocol-error flag for beats issued without a grant
    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            r_err <= 1'b0;
        end else if (w_stray) begin
            r_err <= 1'b1;
        end
    end

    // RAM port: only the granted side reaches the memory
    assign w_rd_fire = r_rgnt && bus.rbeat;
    assign w_addr    = r_wgnt ? bus.waddr : bus.raddr;
    assign w_data    = bus.wdata;
    assign w_we      = (r_wgnt && bus.wbeat) ? bus.wstrb : '0;

    assign bus.rgnt     = r_rgnt;
    assign bus.wgnt     = r_wgnt;
    assign bus.usr_ce   = w_rd_fire || (r_wgnt && bus.wbeat);
    assign bus.usr_a    = w_addr;
    assign bus.usr_d    = w_data;
    assign bus.usr_we   = w_we;
    assign bus.err_beat = r_err;

    // Read markers travel alongside the RAM latency, independent of later grants
    asi_arb_qpipe #(
        .W     (ASI_Q_W),
        .DEPTH (SLV_WS)
    ) u_qpipe (
        .usr_clk     (usr_clk),
        .usr_reset_n (usr_reset_n),
        .i_d         ({w_rd_fire, w_rd_fire && bus.rlast}),
        .o_q         (w_q)
    );

    assign bus.q_valid = w_q[1];
    assign bus.q_last  = w_q[0];
endmodule

// File: tb/tb_asi_arb.sv
// Bench for asi_arb: two instances (write-priority/MAXC=4/latency 2 and
// read-priority/MAXC=2/latency 1) driven by directed scenarios and by
// random traffic checked against a cycle-level reference model.
`timescale 1ns/1ps
module tb_asi_arb;
    localparam int DW = 128;
    localparam int AW = 40;
    localparam int SW = 16;
    localparam int O_IDLE = 0;
    localparam int O_RD   = 1;
    localparam int O_WR   = 2;

    logic usr_clk = 1'b0;
    logic usr_reset_n = 1'b0;
    always #5 usr_clk = ~usr_clk;

    typedef struct packed {
        logic          rreq;
        logic          wreq;
        logic          rbeat;
        logic          rlast;
        logic          wbeat;
        logic          wlast;
        logic [AW-1:0] raddr;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } stim_t;

    stim_t         st  [2];
    logic          g_r [2];
    logic          g_w [2];
    logic          ce  [2];
    logic          qv  [2];
    logic          ql  [2];
    logic          err [2];
    logic [AW-1:0] ua  [2];
    logic [DW-1:0] ud  [2];
    logic [SW-1:0] uwe [2];

    int errors = 0;
    int checks = 0;

    asi_arb_if #(.AXI_DW(DW), .AXI_AW(AW), .AXI_WSTRBW(SW)) bus [2] ();

    for (genvar k = 0; k < 2; k++) begin : g_dut
        assign bus[k].rreq  = st[k].rreq;
        assign bus[k].wreq  = st[k].wreq;
        assign bus[k].rbeat = st[k].rbeat;
        assign bus[k].rlast = st[k].rlast;
        assign bus[k].wbeat = st[k].wbeat;
        assign bus[k].wlast = st[k].wlast;
        assign bus[k].raddr = st[k].raddr;
        assign bus[k].waddr = st[k].waddr;
        assign bus[k].wdata = st[k].wdata;
        assign bus[k].wstrb = st[k].wstrb;
        assign g_r[k] = bus[k].rgnt;
        assign g_w[k] = bus[k].wgnt;
        assign ce[k]  = bus[k].usr_ce;
        assign qv[k]  = bus[k].q_valid;
        assign ql[k]  = bus[k].q_last;
        assign err[k] = bus[k].err_beat;
        assign ua[k]  = bus[k].usr_a;
        assign ud[k]  = bus[k].usr_d;
        assign uwe[k] = bus[k].usr_we;

        asi_arb #(
            .AXI_DW(DW), .AXI_AW(AW), .AXI_WSTRBW(SW),
            .ARB_PRI(k), .ARB_MAXC(k == 0 ? 4 : 2), .SLV_WS(k == 0 ? 2 : 1)
        ) u_dut (
            .usr_clk(usr_clk), .usr_reset_n(usr_reset_n), .bus(bus[k])
        );
    end

    function automatic int pri_of(int k);  return (k == 0) ? 0 : 1; endfunction
    function automatic int maxc_of(int k); return (k == 0) ? 4 : 2; endfunction
    function automatic int ws_of(int k);   return (k == 0) ? 2 : 1; endfunction

    // Reference model: who owns the RAM, how many bursts in a row it has had
    // while the other side waited, the sticky error and read-marker history.
    int         m_own  [2];
    int         m_cnt  [2];
    logic       m_err  [2];
    logic [1:0] m_hist [2][8];

    task automatic clear_in();
        for (int k = 0; k < 2; k++) st[k] = '0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k] = O_IDLE;
            m_cnt[k] = 0;
            m_err[k] = 1'b0;
            for (int i = 0; i < 8; i++) m_hist[k][i] = 2'b00;
        end
    endtask

    task automatic model_edge();
        logic fire, cur, oth, endb, pri_oth;
        int   other;
        for (int k = 0; k < 2; k++) begin
            fire = (m_own[k] == O_RD) && st[k].rbeat;
            for (int i = 7; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
            m_hist[k][0] = {fire, fire && st[k].rlast};
            if ((st[k].rbeat && m_own[k] != O_RD) || (st[k].wbeat && m_own[k] != O_WR))
                m_err[k] = 1'b1;
            if (m_own[k] == O_IDLE) begin
                m_cnt[k] = 0;
                if (st[k].rreq && st[k].wreq) m_own[k] = (pri_of(k) == 1) ? O_RD : O_WR;
                else if (st[k].rreq)          m_own[k] = O_RD;
                else if (st[k].wreq)          m_own[k] = O_WR;
            end else begin
                other   = (m_own[k] == O_RD) ? O_WR : O_RD;
                cur     = (m_own[k] == O_RD) ? st[k].rreq : st[k].wreq;
                oth     = (m_own[k] == O_RD) ? st[k].wreq : st[k].rreq;
                endb    = (m_own[k] == O_RD) ? (st[k].rbeat && st[k].rlast)
                                             : (st[k].wbeat && st[k].wlast);
                pri_oth = (other == O_WR && pri_of(k) == 0) || (other == O_RD && pri_of(k) == 1);
                if (endb) begin
                    if (oth && (!cur || pri_oth || m_cnt[k] == maxc_of(k) - 1)) begin
                        m_own[k] = other;
                        m_cnt[k] = 0;
                    end else if (cur) begin
                        m_cnt[k] = oth ? m_cnt[k] + 1 : 0;
                    end else begin
                        m_own[k] = O_IDLE;
                        m_cnt[k] = 0;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge usr_clk);
        @(negedge usr_clk);
    endtask

    task automatic do_reset();
        usr_reset_n = 1'b0;
        clear_in();
        model_reset();
        @(negedge usr_clk);
        @(negedge usr_clk);
        usr_reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        usr_reset_n = 1'b0;
        clear_in();
        model_reset();
        for (int k = 0; k < 2; k++) begin
            st[k].wbeat = 1'b1; st[k].rbeat = 1'b1; st[k].wstrb = '1;
            st[k].rreq  = 1'b1; st[k].wreq  = 1'b1;
        end
        @(negedge usr_clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({g_r[k], g_w[k], ce[k], qv[k], ql[k], err[k], |uwe[k]} !== 7'b0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got %b expected 0000000", k,
                         {g_r[k], g_w[k], ce[k], qv[k], ql[k], err[k], |uwe[k]});
            end
        end
        @(negedge usr_clk);
        clear_in();
        usr_reset_n = 1'b1;
        #1;
    endtask

    task automatic test_idle_beats();
        for (int k = 0; k < 2; k++) begin
            st[k].rbeat = 1'b1; st[k].rlast = 1'b1; st[k].wbeat = 1'b1; st[k].wlast = 1'b1;
        end
        #1;
        checks++;
        if (ce[0] !== 1'b0) begin
            errors++; $display("FAIL idle_ce: got %b expected 0", ce[0]);
        end
        tick();
        clear_in();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({g_r[k], g_w[k], err[k]} !== 3'b001) begin
                errors++;
                $display("FAIL idle_beats dut%0d: got rgnt,wgnt,err=%b expected 001", k,
                         {g_r[k], g_w[k], err[k]});
            end
        end
        do_reset();
    endtask

    task automatic test_tiebreak();
        for (int k = 0; k < 2; k++) begin st[k].rreq = 1'b1; st[k].wreq = 1'b1; end
        #1;
        tick();
        clear_in();
        #1;
        checks++;
        if ({g_r[0], g_w[0]} !== 2'b01) begin
            errors++; $display("FAIL tiebreak_pri0: got rgnt,wgnt=%b expected 01", {g_r[0], g_w[0]});
        end
        checks++;
        if ({g_r[1], g_w[1]} !== 2'b10) begin
            errors++; $display("FAIL tiebreak_pri1: got rgnt,wgnt=%b expected 10", {g_r[1], g_w[1]});
        end
        st[0].wbeat = 1'b1; st[0].wlast = 1'b1; st[0].rreq = 1'b1;
        st[1].rbeat = 1'b1; st[1].rlast = 1'b1; st[1].wreq = 1'b1;
        #1;
        tick();
        clear_in();
        #1;
        checks++;
        if ({g_r[0], g_w[0]} !== 2'b10) begin
            errors++; $display("FAIL handover_w2r: got rgnt,wgnt=%b expected 10", {g_r[0], g_w[0]});
        end
        checks++;
        if ({g_r[1], g_w[1]} !== 2'b01) begin
            errors++; $display("FAIL handover_r2w: got rgnt,wgnt=%b expected 01", {g_r[1], g_w[1]});
        end
        do_reset();
    endtask

    task automatic test_fairness();
        logic exp_w;
        for (int k = 0; k < 2; k++) begin st[k].rreq = 1'b1; st[k].wreq = 1'b1; end
        #1;
        tick();
        for (int c = 0; c < 15; c++) begin
            for (int k = 0; k < 2; k++) begin
                st[k].wbeat = (m_own[k] == O_WR); st[k].wlast = (m_own[k] == O_WR);
                st[k].rbeat = (m_own[k] == O_RD); st[k].rlast = (m_own[k] == O_RD);
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                exp_w = (k == 0) ? ((c % 5) < 4) : ((c % 3) == 2);
                checks++;
                if ({g_r[k], g_w[k]} !== {~exp_w, exp_w}) begin
                    errors++;
                    $display("FAIL fairness dut%0d burst%0d: got rgnt,wgnt=%b expected %b", k, c,
                             {g_r[k], g_w[k]}, {~exp_w, exp_w});
                end
            end
            tick();
        end
        do_reset();
    endtask

    task automatic test_read_latency();
        st[0].rreq = 1'b1;
        #1;
        tick();
        st[0].rreq = 1'b0;
        for (int j = 0; j < 8; j++) begin
            st[0].rbeat = (j < 4);
            st[0].rlast = (j == 3);
            st[0].raddr = (j < 4) ? AW'(40'h10 + j) : '0;
            #1;
            checks++;
            if ({qv[0], ql[0]} !== {(j >= 2 && j <= 5), (j == 5)}) begin
                errors++;
                $display("FAIL read_latency cyc%0d: got q_valid,q_last=%b expected %b", j,
                         {qv[0], ql[0]}, {(j >= 2 && j <= 5), (j == 5)});
            end
            if (j < 4) begin
                checks++;
                if ({ce[0], ua[0]} !== {1'b1, AW'(40'h10 + j)}) begin
                    errors++;
                    $display("FAIL read_addr beat%0d: got ce=%b a=%0h expected ce=1 a=%0h", j,
                             ce[0], ua[0], 40'h10 + j);
                end
            end
            tick();
        end
        do_reset();
    endtask

    task automatic test_write_strobe();
        st[0].wreq = 1'b1;
        #1;
        tick();
        st[0].wreq  = 1'b0;
        st[0].wbeat = 1'b1;
        st[0].wstrb = 16'h00F0;
        st[0].waddr = 40'h12_3456_789A;
        st[0].raddr = 40'h55;
        st[0].wdata = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
        #1;
        checks++;
        if ({ce[0], uwe[0], ua[0]} !== {1'b1, 16'h00F0, 40'h12_3456_789A}) begin
            errors++;
            $display("FAIL write_port: got ce=%b we=%h a=%h expected ce=1 we=00f0 a=123456789a",
                     ce[0], uwe[0], ua[0]);
        end
        checks++;
        if (ud[0] !== st[0].wdata) begin
            errors++; $display("FAIL write_data: got %h expected %h", ud[0], st[0].wdata);
        end
        tick();
        st[0].wlast = 1'b1;
        st[0].rreq  = 1'b1;
        #1;
        tick();
        clear_in();
        st[0].wbeat = 1'b1;
        st[0].wstrb = 16'h00F0;
        st[0].raddr = 40'h77;
        st[0].waddr = 40'h99;
        #1;
        checks++;
        if ({g_r[0], ce[0], uwe[0], ua[0], err[0]} !== {1'b1, 1'b0, 16'h0000, 40'h77, 1'b0}) begin
            errors++;
            $display("FAIL stray_wbeat_port: got rgnt=%b ce=%b we=%h a=%h err=%b expected 1 0 0000 77 0",
                     g_r[0], ce[0], uwe[0], ua[0], err[0]);
        end
        tick();
        clear_in();
        #1;
        checks++;
        if (err[0] !== 1'b1) begin
            errors++; $display("FAIL stray_wbeat_err: got %b expected 1", err[0]);
        end
        do_reset();
    endtask

    task automatic test_reset_midburst();
        st[0].wreq = 1'b1;
        #1;
        tick();
        st[0].wreq  = 1'b0;
        st[0].wbeat = 1'b1;
        st[0].wstrb = '1;
        #1;
        tick();
        #1;
        checks++;
        if ({g_w[0], ce[0]} !== 2'b11) begin
            errors++; $display("FAIL midburst_active: got wgnt,ce=%b expected 11", {g_w[0], ce[0]});
        end
        #2;
        usr_reset_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({g_r[k], g_w[k], ce[k], qv[k], ql[k], err[k], |uwe[k]} !== 7'b0) begin
                errors++;
                $display("FAIL midburst_reset dut%0d: got %b expected 0000000", k,
                         {g_r[k], g_w[k], ce[k], qv[k], ql[k], err[k], |uwe[k]});
            end
        end
        model_reset();
        clear_in();
        @(negedge usr_clk);
        usr_reset_n = 1'b1;
        st[0].wreq = 1'b1;
        #1;
        tick();
        clear_in();
        #1;
        checks++;
        if ({g_r[0], g_w[0]} !== 2'b01) begin
            errors++; $display("FAIL post_reset_grant: got rgnt,wgnt=%b expected 01", {g_r[0], g_w[0]});
        end
        do_reset();
    endtask

    task automatic test_read_to_write();
        st[0].rreq = 1'b1;
        #1;
        tick();
        st[0].rreq  = 1'b0;
        st[0].wreq  = 1'b1;
        st[0].rbeat = 1'b1;
        st[0].rlast = 1'b1;
        st[0].raddr = 40'h20;
        #1;
        tick();
        clear_in();
        #1;
        checks++;
        if ({g_r[0], g_w[0], qv[0]} !== 3'b010) begin
            errors++;
            $display("FAIL r2w_no_bubble: got rgnt,wgnt,q_valid=%b expected 010", {g_r[0], g_w[0], qv[0]});
        end
        tick();
        #1;
        checks++;
        if ({g_w[0], qv[0], ql[0]} !== 3'b111) begin
            errors++;
            $display("FAIL r2w_q_drain: got wgnt,q_valid,q_last=%b expected 111", {g_w[0], qv[0], ql[0]});
        end
        do_reset();
    endtask

    task automatic test_random();
        logic          eg_r, eg_w, ece;
        logic [SW-1:0] ewe;
        logic [AW-1:0] ea;
        logic [1:0]    eq;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc % 150 == 0) do_reset();
            for (int k = 0; k < 2; k++) begin
                st[k].rreq  = ($urandom % 3) != 0;
                st[k].wreq  = ($urandom % 3) != 0;
                st[k].rbeat = (m_own[k] == O_RD) ? (($urandom % 4) != 0) : (($urandom % 300) == 0);
                st[k].wbeat = (m_own[k] == O_WR) ? (($urandom % 4) != 0) : (($urandom % 300) == 0);
                st[k].rlast = ($urandom % 3) == 0;
                st[k].wlast = ($urandom % 3) == 0;
                st[k].raddr = AW'({$urandom(), $urandom()});
                st[k].waddr = AW'({$urandom(), $urandom()});
                st[k].wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
                st[k].wstrb = SW'($urandom());
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                eg_r = (m_own[k] == O_RD);
                eg_w = (m_own[k] == O_WR);
                ece  = (eg_r && st[k].rbeat) || (eg_w && st[k].wbeat);
                ewe  = (eg_w && st[k].wbeat) ? st[k].wstrb : '0;
                ea   = eg_w ? st[k].waddr : st[k].raddr;
                eq   = m_hist[k][ws_of(k) - 1];
                checks++;
                if ({g_r[k], g_w[k], ce[k], qv[k], ql[k], err[k]} !== {eg_r, eg_w, ece, eq, m_err[k]}) begin
                    errors++;
                    $display("FAIL rand_ctrl dut%0d cyc%0d: got rgnt,wgnt,ce,qv,ql,err=%b expected %b", k, cyc,
                             {g_r[k], g_w[k], ce[k], qv[k], ql[k], err[k]}, {eg_r, eg_w, ece, eq, m_err[k]});
                end
                checks++;
                if ({uwe[k], ua[k], ud[k]} !== {ewe, ea, st[k].wdata}) begin
                    errors++;
                    $display("FAIL rand_ram dut%0d cyc%0d: got we=%h a=%h d=%h expected we=%h a=%h d=%h", k, cyc,
                             uwe[k], ua[k], ud[k], ewe, ea, st[k].wdata);
                end
            end
            tick();
        end
    endtask

    initial begin
        clear_in();
        model_reset();
        @(negedge usr_clk);
        test_reset();
        test_idle_beats();
        test_tiebreak();
        test_fairness();
        test_read_latency();
        test_write_strobe();
        test_reset_midburst();
        test_read_to_write();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
